// File: rtl/seq_detect_ctrl.sv
// Run-time programmable serial sequence detector with match counting and
// automatic stop at a programmed match threshold.
//
// state | meaning
// IDLE  | waiting for start; configuration writes accepted
// RUN   | sampling x on x_valid, detecting and counting matches
// DONE  | threshold reached; count held, configuration writes accepted
module seq_detect_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNT_W  = 8,
    localparam int LW    = $clog2(MAXLEN) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LW-1:0]     cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              start,
    input  logic              stop,
    input  logic              x,
    input  logic              x_valid,
    output logic              z,
    output logic [CNT_W-1:0]  match_count,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [MAXLEN-1:0]   pattern_q;
    logic [LW-1:0]       len_q;
    logic                overlap_q;
    logic [CNT_W-1:0]    thresh_q;
    logic [MAXLEN-2:0]   hist_q;
    logic [LW-1:0]       fill_q;

    logic [MAXLEN-1:0]   shifted;
    logic [MAXLEN-1:0]   mask;
    logic [LW-1:0]       fill_inc;
    logic [CNT_W-1:0]    cnt_inc;
    logic                hit;
    logic                len_ok;

    always_comb begin
        shifted = {hist_q, x};
        mask    = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        // fill_q + 1 never overflows LW bits since fill_q saturates at MAXLEN
        hit      = ((fill_q + LW'(1)) >= len_q) && ((shifted & mask) == (pattern_q & mask));
        fill_inc = (fill_q == LW'(MAXLEN)) ? fill_q : fill_q + LW'(1);
        cnt_inc  = (&match_count) ? match_count : match_count + CNT_W'(1);
        len_ok   = (cfg_len != '0) && (cfg_len <= LW'(MAXLEN));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pattern_q   <= MAXLEN'(4'b0110);
            len_q       <= LW'(4);
            overlap_q   <= 1'b1;
            thresh_q    <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            z           <= 1'b0;
            match_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            z       <= 1'b0;
            cfg_err <= 1'b0;

            if (cfg_wr) begin
                if (state != RUN && len_ok) begin
                    pattern_q <= cfg_pattern;
                    len_q     <= cfg_len;
                    overlap_q <= cfg_overlap;
                    thresh_q  <= cfg_thresh;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        match_count <= '0;
                        hist_q      <= '0;
                        fill_q      <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (x_valid) begin
                        hist_q <= shifted[MAXLEN-2:0];
                        fill_q <= fill_inc;
                        if (hit) begin
                            z           <= 1'b1;
                            match_count <= cnt_inc;
                            if (!overlap_q) begin
                                hist_q <= '0;
                                fill_q <= '0;
                            end
                            if (thresh_q != '0 && cnt_inc == thresh_q) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seq_detect_ctrl;

    localparam int MAXLEN = 8;
    localparam int CNT_W  = 8;
    localparam int LW     = $clog2(MAXLEN) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_wr = 1'b0;
    logic [MAXLEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]     cfg_len = '0;
    logic              cfg_overlap = 1'b0;
    logic [CNT_W-1:0]  cfg_thresh = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              x = 1'b0;
    logic              x_valid = 1'b0;
    logic              z;
    logic [CNT_W-1:0]  match_count;
    logic              busy;
    logic              done;
    logic              cfg_err;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 0;

    seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
        .start(start), .stop(stop), .x(x), .x_valid(x_valid), .z(z),
        .match_count(match_count), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: bits received since the last clear, newest at the back.
    bit        m_run = 0, m_done = 0, m_z = 0, m_err = 0;
    int        m_cnt = 0;
    bit [7:0]  m_pat = 8'b0110;
    int        m_len = 4;
    bit        m_ovl = 1;
    int        m_thr = 0;
    bit        q[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_done = 0; m_z = 0; m_err = 0; m_cnt = 0;
            m_pat = 8'b0110; m_len = 4; m_ovl = 1; m_thr = 0;
            q.delete();
        end else begin
            bit matched;
            m_z = 0;
            m_err = 0;
            if (cfg_wr) begin
                if (!m_run && int'(cfg_len) >= 1 && int'(cfg_len) <= MAXLEN) begin
                    m_pat = cfg_pattern; m_len = int'(cfg_len);
                    m_ovl = cfg_overlap; m_thr = int'(cfg_thresh);
                end else begin
                    m_err = 1;
                end
            end
            if (m_run) begin
                if (stop) begin
                    m_run = 0;
                end else if (x_valid) begin
                    q.push_back(x);
                    if (q.size() > MAXLEN) void'(q.pop_front());
                    matched = (q.size() >= m_len);
                    for (int k = 0; k < m_len; k++)
                        if (matched && q[q.size()-1-k] != m_pat[k]) matched = 0;
                    if (matched) begin
                        m_z = 1;
                        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                        if (!m_ovl) q.delete();
                        if (m_thr != 0 && m_cnt == m_thr) begin
                            m_run = 0;
                            m_done = 1;
                        end
                    end
                end
            end else if (start) begin
                m_run = 1; m_done = 0; m_cnt = 0;
                q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("z", int'(z), int'(m_z));
            chk("match_count", int'(match_count), m_cnt);
            chk("busy", int'(busy), int'(m_run));
            chk("done", int'(done), int'(m_done));
            chk("cfg_err", int'(cfg_err), int'(m_err));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [7:0] p, input int len, input bit ovl, input int thr);
        cfg_pattern = p; cfg_len = LW'(len); cfg_overlap = ovl; cfg_thresh = CNT_W'(thr);
        cfg_wr = 1; step(); cfg_wr = 0;
    endtask

    task automatic do_start();
        start = 1; step(); start = 0;
    endtask

    task automatic do_stop();
        stop = 1; step(); stop = 0;
    endtask

    // s[10] is the first bit of the stream; zm[i] = z seen right after bit i
    task automatic run_stream(input logic [10:0] s, input int nbits, input bit gaps,
                              output logic [10:0] zm, output int gapz);
        zm = '0;
        gapz = 0;
        for (int i = 0; i < nbits; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    x_valid = 0; x = 1'($urandom);
                    step();
                    if (z) gapz++;
                end
            end
            x = s[10-i]; x_valid = 1;
            step();
            zm[i] = z;
        end
        x_valid = 0;
    endtask

    logic [10:0] stream;
    logic [10:0] zm;
    int          gapz;

    initial begin
        stream = 11'b01101100110;
        #1 reset = 0;
        step(); step();
        chk("rst_z", int'(z), 0);
        chk("rst_count", int'(match_count), 0);
        chk("rst_busy_done", int'({busy, done}), 0);
        reset = 1;
        cmp_en = 1;
        step();

        // Scenario 1: defaults, overlapping
        do_start();
        chk("s1_busy_after_start", int'(busy), 1);
        run_stream(stream, 11, 0, zm, gapz);
        chk("s1_zmask", int'(zm), 'h448);
        chk("s1_count", int'(match_count), 3);
        chk("s1_busy", int'(busy), 1);
        do_stop();
        chk("s1_count_kept_after_stop", int'(match_count), 3);

        // Scenario 2: non-overlapping
        write_cfg(8'b0110, 4, 0, 0);
        do_start();
        run_stream(stream, 11, 0, zm, gapz);
        chk("s2_zmask", int'(zm), 'h408);
        chk("s2_count", int'(match_count), 2);
        do_stop();

        // Scenario 3: threshold 2
        write_cfg(8'b0110, 4, 1, 2);
        do_start();
        run_stream(stream, 11, 0, zm, gapz);
        chk("s3_zmask", int'(zm), 'h048);
        chk("s3_done", int'(done), 1);
        chk("s3_busy", int'(busy), 0);
        chk("s3_count", int'(match_count), 2);
        do_stop();
        chk("s3_done_after_stop", int'(done), 1);

        // Scenario 4: written in DONE, stream with x_valid gaps
        write_cfg(8'b0110, 4, 1, 0);
        do_start();
        chk("s4_done_cleared", int'(done), 0);
        run_stream(stream, 11, 1, zm, gapz);
        chk("s4_zmask", int'(zm), 'h448);
        chk("s4_gap_z", gapz, 0);
        chk("s4_count", int'(match_count), 3);

        // Scenario 5: rejected writes
        write_cfg(8'b1111, 5, 0, 1);
        chk("s5_err_busy", int'(cfg_err), 1);
        step();
        chk("s5_err_one_cycle", int'(cfg_err), 0);
        do_stop();
        write_cfg(8'b1111, 0, 0, 1);
        chk("s5_err_len0", int'(cfg_err), 1);
        write_cfg(8'b1111, MAXLEN + 1, 0, 1);
        chk("s5_err_len9", int'(cfg_err), 1);
        step();
        do_start();
        run_stream(stream, 11, 0, zm, gapz);
        chk("s5_zmask", int'(zm), 'h448);
        chk("s5_count", int'(match_count), 3);
        do_stop();

        // Scenario 6: reset mid-run restores defaults
        write_cfg(8'b1011, 4, 0, 5);
        do_start();
        run_stream(11'b10110000000, 5, 0, zm, gapz);
        chk("s6_zmask", int'(zm), 'h008);
        @(posedge clk);
        #2 reset = 0;
        #1;
        chk("s6_rst_z", int'(z), 0);
        chk("s6_rst_count", int'(match_count), 0);
        chk("s6_rst_busy", int'(busy), 0);
        chk("s6_rst_done_err", int'({done, cfg_err}), 0);
        @(negedge clk);
        #1 reset = 1;
        step();
        do_start();
        run_stream(stream, 11, 0, zm, gapz);
        chk("s6_zmask_defaults", int'(zm), 'h448);
        chk("s6_count_defaults", int'(match_count), 3);
        do_stop();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            cfg_wr      = ($urandom_range(0, 15) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = LW'($urandom_range(0, 9));
            cfg_overlap = 1'($urandom);
            cfg_thresh  = CNT_W'($urandom_range(0, 6));
            start       = ($urandom_range(0, 19) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            x           = 1'($urandom);
            x_valid     = ($urandom_range(0, 3) != 0);
            step();
        end
        cfg_wr = 0; start = 0; stop = 0; x_valid = 0;
        step();
        cmp_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
